// File: rtl/ysyx_23060136_div_unit.sv
// ysyx_23060136_div_unit
//   Iterative radix-2 restoring divider for the RV64M DIV/DIVU/REM/REMU and
//   their *W variants. Quotient and remainder are returned together and held
//   until the consumer takes them.
// Ports
//   clk, rst                     core clock, synchronous active-high reset
//   in_valid_i / in_ready_o      operand handshake (ready only when idle)
//   dividend_i, divisor_i        rs1, rs2
//   signed_i, word_i             op kind: signed/unsigned, 32-bit word mode
//   flush_i                      abandon whatever is in flight
//   out_valid_o / out_ready_i    result handshake
//   quotient_o, remainder_o      results, stable while out_valid_o is high
module ysyx_23060136_div_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic            signed_i,
    input  logic            word_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_W = {{(XLEN-31){1'b1}}, 31'b0};

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;   // partial remainder
    logic [XLEN-1:0] dvd_q, dvd_d;   // dividend shifting out, quotient shifting in
    logic [XLEN-1:0] dsr_q, dsr_d;
    logic            qneg_q, qneg_d, rneg_q, rneg_d, word_q, word_d;
    logic [XLEN-1:0] quot_q, quot_d, remo_q, remo_d;

    // operand preparation
    logic [XLEN-1:0] a_p, b_p, a_abs, b_abs;
    logic            sa, sb, is_div0, is_ovf, accept;

    always_comb begin
        a_p = dividend_i;
        b_p = divisor_i;
        if (word_i) begin
            a_p = {{(XLEN-32){signed_i & dividend_i[31]}}, dividend_i[31:0]};
            b_p = {{(XLEN-32){signed_i & divisor_i[31]}}, divisor_i[31:0]};
        end
        sa      = signed_i & a_p[XLEN-1];
        sb      = signed_i & b_p[XLEN-1];
        a_abs   = sa ? -a_p : a_p;
        b_abs   = sb ? -b_p : b_p;
        is_div0 = (b_p == '0);
        is_ovf  = signed_i && (b_p == '1) && (a_p == (word_i ? MIN_W : MIN_D));
        accept  = in_valid_i && (state_q == S_IDLE) && !flush_i;
    end

    // one restoring step; the compare is XLEN+1 wide, but when it succeeds the
    // difference is below the divisor, so the low XLEN bits of the subtraction
    // are exact
    logic [XLEN:0]   sh;
    logic            qbit;
    logic [XLEN-1:0] trial;
    logic [XLEN-1:0] qf, rf;

    always_comb begin
        sh    = {rem_q, dvd_q[XLEN-1]};
        qbit  = (sh >= {1'b0, dsr_q});
        trial = sh[XLEN-1:0] - dsr_q;
        qf    = qneg_q ? -dvd_q : dvd_q;
        rf    = rneg_q ? -rem_q : rem_q;
        if (word_q) begin
            qf = {{(XLEN-32){qf[31]}}, qf[31:0]};
            rf = {{(XLEN-32){rf[31]}}, rf[31:0]};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        word_d  = word_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        case (state_q)
            S_IDLE: if (accept) begin
                state_d = S_CALC;
                word_d  = word_i;
                dsr_d   = b_abs;
                // special cases skip iteration (cnt=0) and carry their
                // final values through the finalise cycle unnegated
                if (is_div0) begin
                    cnt_d = '0; dvd_d = '1; rem_d = a_p;
                    qneg_d = 1'b0; rneg_d = 1'b0;
                end else if (is_ovf) begin
                    cnt_d = '0; dvd_d = a_p; rem_d = '0;
                    qneg_d = 1'b0; rneg_d = 1'b0;
                end else begin
                    cnt_d  = word_i ? CW'(32) : CW'(XLEN);
                    // word operands sit in the top half so 32 shifts consume them
                    dvd_d  = word_i ? (a_abs << 32) : a_abs;
                    rem_d  = '0;
                    qneg_d = sa ^ sb;
                    rneg_d = sa;
                end
            end
            S_CALC: begin
                if (cnt_q != '0) begin
                    // counts N..1 while iterating, then one finalise cycle
                    rem_d = qbit ? trial : sh[XLEN-1:0];
                    dvd_d = {dvd_q[XLEN-2:0], qbit};
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    quot_d  = qf;
                    remo_d  = rf;
                    state_d = S_DONE;
                end
            end
            S_DONE: if (out_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush_i) state_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            word_q  <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            word_q  <= word_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
        end
    end

    assign in_ready_o  = (state_q == S_IDLE);
    assign out_valid_o = (state_q == S_DONE);
    assign quotient_o  = quot_q;
    assign remainder_o = remo_q;
endmodule

// File: tb/tb_ysyx_23060136_div_unit.sv
module tb_ysyx_23060136_div_unit;
    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 1'b0, in_ready, signed_op = 1'b0, word_op = 1'b0;
    logic        flush = 1'b0, out_valid, out_ready = 1'b1;
    logic [63:0] dividend = '0, divisor = '0, quotient, remainder;

    ysyx_23060136_div_unit #(.XLEN(64)) dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .dividend_i(dividend), .divisor_i(divisor), .signed_i(signed_op),
        .word_i(word_op), .flush_i(flush), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .quotient_o(quotient), .remainder_o(remainder));

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0, nvec = 0, nerr = 0;
    logic rdy_rand = 1'b0, vld_prev = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rdy_rand) out_ready <= ($urandom_range(0, 3) != 0);
    end

    // reference: plain RISC-V M-extension division semantics
    function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                  input logic s, input logic w,
                                  output logic [63:0] q, output logic [63:0] r,
                                  output int lat);
        logic [31:0] a32, b32, q32, r32;
        lat = w ? 33 : 65;
        if (w) begin
            a32 = a[31:0]; b32 = b[31:0];
            if (b32 == 0) begin q32 = '1; r32 = a32; lat = 1; end
            else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32; r32 = 0; lat = 1;
            end else if (s) begin
                q32 = $signed(a32) / $signed(b32);
                r32 = $signed(a32) % $signed(b32);
            end else begin
                q32 = a32 / b32; r32 = a32 % b32;
            end
            q = {{32{q32[31]}}, q32};
            r = {{32{r32[31]}}, r32};
        end else begin
            if (b == 0) begin q = '1; r = a; lat = 1; end
            else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
                q = a; r = 0; lat = 1;
            end else if (s) begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end else begin
                q = a / b; r = a % b;
            end
        end
    endfunction

    // monitor: checks every cycle the result is presented (so a stall also
    // checks stability), latency on the rising edge of out_valid
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    nvec++; nerr++;
                    $display("FAIL unexpected_valid q=%h r=%h (no result outstanding)", quotient, remainder);
                end else begin
                    if (!vld_prev) begin
                        nvec++;
                        if (cyc - sb[0].acc != sb[0].lat) begin
                            nerr++;
                            $display("FAIL latency got=%0d want=%0d", cyc - sb[0].acc, sb[0].lat);
                        end
                    end
                    nvec++;
                    if (quotient !== sb[0].q || remainder !== sb[0].r) begin
                        nerr++;
                        $display("FAIL result q=%h r=%h want q=%h r=%h", quotient, remainder, sb[0].q, sb[0].r);
                    end
                    if (out_ready) void'(sb.pop_front());
                end
            end
            vld_prev = out_valid;
        end else vld_prev = 1'b0;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        nvec++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic s, input logic w);
        exp_t e;
        int k = 0;
        while (!in_ready && k < 400) begin @(negedge clk); k++; end
        if (!in_ready) check("issue_timeout", 64'(in_ready), 64'd1);
        dividend = a; divisor = b; signed_op = s; word_op = w; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        model(a, b, s, w, e.q, e.r, e.lat);
        e.acc = cyc;
        sb.push_back(e);
    endtask

    task automatic drain();
        int k = 0;
        while ((sb.size() != 0 || !in_ready) && k < 400) begin @(negedge clk); k++; end
        if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        logic [63:0] a, b;
        int k;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_quotient", quotient, 64'd0);
        check("rst_remainder", remainder, 64'd0);

        // directed cases; values and latencies come from the model
        issue(64'd100, 64'd7, 1'b0, 1'b0); drain();
        issue(-64'sd7, 64'd2, 1'b1, 1'b0); drain();
        issue(64'h0000_0001_8000_0000, '1, 1'b1, 1'b1); drain();
        issue(64'd5, 64'd0, 1'b0, 1'b0); drain();
        issue(64'h8000_0000_0000_0000, '1, 1'b1, 1'b0); drain();
        issue(64'h1234_5678_0000_0007, 64'hFFFF_FFFF_0000_0000, 1'b0, 1'b1); drain();

        // stalled result: held stable for 20 cycles, no accept while DONE
        issue(64'h0000_0000_FFFF_FFFF, 64'd10, 1'b0, 1'b1);
        out_ready = 1'b0;
        k = 0;
        while (!out_valid && k < 100) begin @(posedge clk); #1; k++; end
        repeat (20) @(posedge clk);
        #1 check("stall_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("post_hs_in_ready", 64'(in_ready), 64'd1);
        check("post_hs_out_valid", 64'(out_valid), 64'd0);

        // flush mid-calculation discards the op
        issue(64'd1000, 64'd3, 1'b0, 1'b0);
        repeat (30) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        sb.delete();
        check("flush_in_ready", 64'(in_ready), 64'd1);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        repeat (70) @(posedge clk);
        #1 check("flush_still_idle", 64'(in_ready), 64'd1);

        // reset mid-calculation clears everything
        issue(64'd77, 64'd5, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        sb.delete();
        check("rst2_in_ready", 64'(in_ready), 64'd1);
        check("rst2_out_valid", 64'(out_valid), 64'd0);
        check("rst2_quotient", quotient, 64'd0);
        check("rst2_remainder", remainder, 64'd0);

        // flush beats in_valid in IDLE
        dividend = 64'd9; divisor = 64'd2; signed_op = 1'b0; word_op = 1'b0;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
        check("flush_vs_valid", 64'(in_ready), 64'd1);
        repeat (5) @(posedge clk);
        #1 check("flush_vs_valid_idle", 64'(in_ready), 64'd1);

        issue(64'd1000, 64'd3, 1'b1, 1'b0); drain();

        // randomized ops with random consumer backpressure
        rdy_rand = 1'b1;
        for (int i = 0; i < 60; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: b = '0;
                1: b = '1;
                2: b = 64'($urandom_range(1, 1000));
                3: begin a = 64'h8000_0000_0000_0000; b = '1; end
                4: begin a = {$urandom, 32'h8000_0000}; b = {$urandom, 32'hFFFF_FFFF}; end
                5: b = {32'd0, $urandom};
                default: ;
            endcase
            issue(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drain();
        rdy_rand = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
